prio_deco_pipe: RTL and testbench
=================================

PRIO_DECO_PIPE -- requirements
Module: prio_deco_pipe

Interface
REQ-001 SHALL have parameter CODE_W, default 3, code width in bits.
REQ-002 SHALL have parameter N_OUT, default 8, one-hot width; SHALL equal 2**CODE_W.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream token present.
REQ-006 in_ready  output  1  block accepts the token this cycle.
REQ-007 in_code  input  CODE_W  encoded index, same format as the priority-encoder output.
REQ-008 in_en  input  1  token enable; 0 marks a null token.
REQ-009 out_valid  output  1  one-hot token present.
REQ-010 out_ready  input  1  downstream accepts the token.
REQ-011 out_onehot  output  N_OUT  decoded one-hot; all zero for a null token.
REQ-012 done  input  N_OUT  per-line release pulses.
REQ-013 busy  output  N_OUT  lines issued and not yet released.
REQ-014 issue_cnt  output  8  count of non-null tokens issued, mod 256.

Function
REQ-015 Transfers: input fire = in_valid and in_ready; output fire = out_valid and out_ready.
REQ-016 Pipeline: two registered stages, S1 (code, en) and S2 (one-hot).
REQ-017 Latency: minimum latency from input fire to out_valid SHALL be 2 cycles.
REQ-018 Throughput: with no hazard and out_ready held at 1, the block SHALL sustain one token per cycle.
REQ-019 Input ready: in_ready = !S1.valid or S1 advances this cycle; no combinational path from in_valid to in_ready.
REQ-020 Advance rule: S1 SHALL advance to S2 only when all three hold:
- S2 is empty or output-fires this cycle;
- the token is null or busy[code] = 0;
- the token is null or S2 does not hold a non-null token with the same code.
REQ-021 Decode: S2 SHALL drive out_onehot = 1 << code when en = 1, and all zero when en = 0.
REQ-022 Hold: while out_valid = 1 and out_ready = 0, out_onehot SHALL hold stable.
REQ-023 Busy set: on output fire of a non-null token, busy[code] SHALL set on the next edge.
REQ-024 Busy clear: done[i] = 1 SHALL clear busy[i] on the next edge.
REQ-025 Set and clear on the same bit in the same cycle: set wins and busy stays 1.
REQ-026 done on a bit that is not busy SHALL have no effect.
REQ-027 issue_cnt SHALL increment on each non-null output fire and wrap 255 -> 0.
REQ-028 Null tokens SHALL pass through in order, SHALL never stall on busy, and SHALL not change busy or issue_cnt.
REQ-029 Ordering: tokens SHALL leave in acceptance order; there SHALL be no drop and no duplication.

Reset
REQ-030 With rst_n = 0, the block SHALL immediately force to zero:
- S1.valid, S2.valid, out_valid;
- out_onehot, busy, issue_cnt.
REQ-031 During reset, in_ready SHALL be 0; it SHALL be 1 on the first cycle after release.
REQ-032 Reset mid-transfer SHALL discard in-flight tokens and SHALL not generate a fire.

Structure
REQ-033 Package prio_pkg SHALL hold CODE_W, N_OUT and the token record type (code, en).
REQ-034 One sub-module, code_dec (combinational CODE_W-to-N_OUT decoder with enable), SHALL be instantiated in S2.
REQ-035 The valid/ready logic SHALL stay inline in prio_deco_pipe.

Verification
REQ-036 Streaming: after reset, codes 0..7 with en = 1 back-to-back, out_ready = 1, done pulsed 1 cycle after each fire.
- Required: out_onehot 0x01, 0x02, ... 0x80 on consecutive cycles, first at cycle 2.
- Required: issue_cnt = 8.
REQ-037 Busy hazard: issue code 3; withhold done[3]; send code 3 again.
- Required: the second token stalls in S1 and in_ready = 0.
- Required: after done[3], out_onehot = 0x08 appears 1 cycle later.
REQ-038 Null token: code 5 with en = 0 while busy[5] = 1.
- Required: out_onehot = 0x00 with no stall; busy and issue_cnt unchanged.
REQ-039 Backpressure and simultaneous events: out_ready = 0 for 4 cycles with 3 tokens offered.
- Required: at most 2 accepted, output held stable, order preserved.
- Same-cycle fire of code 2 and done[2]: required busy[2] = 1 afterwards.
REQ-040 Wrap and reset: 256 non-null issues give issue_cnt = 0.
- rst_n asserted while out_valid = 1: required out_valid, busy and issue_cnt = 0 in the same cycle.

Source files
------------

// File: rtl/prio_pkg.sv
// Shared widths and the token record for the priority-decode pipeline.
package prio_pkg;

    localparam int CODE_W = 3;
    localparam int N_OUT  = 1 << CODE_W;

    // One pipeline token: encoded line index plus enable (en = 0 is a null token).
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              en;
    } tok_t;

endpackage

// File: rtl/code_dec.sv
// Combinational code-to-one-hot decoder with enable; all zero when disabled.
module code_dec
    import prio_pkg::*;
#(
    parameter int CODE_W = prio_pkg::CODE_W,
    parameter int N_OUT  = prio_pkg::N_OUT
) (
    input  logic [CODE_W-1:0] code,
    input  logic              en,
    output logic [N_OUT-1:0]  onehot
);

    // Drive a single hot bit at the code position, or nothing for a null token.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[code] = 1'b1;
        end
    end

endmodule

// File: rtl/prio_deco_pipe.sv
// Two-stage decode pipeline: S1 holds (code, en), S2 presents the one-hot.
// S1 is held back while its line is still busy or already sitting in S2,
// so a line is never issued twice before it has been released.
module prio_deco_pipe
    import prio_pkg::*;
#(
    parameter int CODE_W = prio_pkg::CODE_W,
    parameter int N_OUT  = prio_pkg::N_OUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  out_onehot,
    input  logic [N_OUT-1:0]  done,
    output logic [N_OUT-1:0]  busy,
    output logic [7:0]        issue_cnt
);

    tok_t             tok_p1;
    tok_t             tok_p2;
    logic             vld_p1;
    logic             vld_p2;
    logic [N_OUT-1:0] onehot_p2;
    logic [N_OUT-1:0] busy_eff;
    logic [N_OUT-1:0] set_vec;
    logic             in_fire;
    logic             out_fire;
    logic             s2_free;
    logic             hazard_busy;
    logic             hazard_s2;
    logic             stall_p1;
    logic             adv_p1;

    // ---- handshake / hazard control ----
    assign out_fire = vld_p2 & out_ready;
    assign s2_free  = ~vld_p2 | out_ready;

    // A release arriving this cycle frees the line immediately, so a stalled
    // token can move into S2 on the same edge that clears busy.
    assign busy_eff    = busy & ~done;
    assign hazard_busy = busy_eff[tok_p1.code];
    assign hazard_s2   = vld_p2 & tok_p2.en & (tok_p2.code == tok_p1.code);
    assign stall_p1    = tok_p1.en & (hazard_busy | hazard_s2);
    assign adv_p1      = vld_p1 & s2_free & ~stall_p1;

    // in_ready depends only on pipeline state (and reset), never on in_valid.
    assign in_ready = rst_n & (~vld_p1 | adv_p1);
    assign in_fire  = in_valid & in_ready;

    // ---- stage S1: accepted token ----
    // S1 occupancy: fill on input fire, drain when the token advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (in_fire) begin
            vld_p1 <= 1'b1;
        end else if (adv_p1) begin
            vld_p1 <= 1'b0;
        end
    end

    // S1 payload capture; qualified by vld_p1 so no reset is needed.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            tok_p1 <= '{code: in_code, en: in_en};
        end
    end

    // ---- stage S2: token presented downstream ----
    // S2 occupancy: fill when S1 advances, drain on output fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
        end else if (adv_p1) begin
            vld_p2 <= 1'b1;
        end else if (out_fire) begin
            vld_p2 <= 1'b0;
        end
    end

    // S2 payload capture; held while stalled by out_ready = 0.
    always_ff @(posedge clk) begin
        if (adv_p1) begin
            tok_p2 <= tok_p1;
        end
    end

    // Gating the enable with vld_p2 keeps the output at zero when S2 is empty,
    // including the moment reset is asserted.
    code_dec #(
        .CODE_W (CODE_W),
        .N_OUT  (N_OUT)
    ) u_code_dec (
        .code   (tok_p2.code),
        .en     (tok_p2.en & vld_p2),
        .onehot (onehot_p2)
    );

    assign out_valid  = vld_p2;
    assign out_onehot = onehot_p2;

    // ---- issue tracking ----
    // A null token decodes to zero, so it sets no busy bit.
    assign set_vec = out_fire ? onehot_p2 : '0;

    // Busy lines: releases clear, issues set, and a set beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~done) | set_vec;
        end
    end

    // Count of non-null issues, wrapping naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
        end else if (out_fire && tok_p2.en) begin
            issue_cnt <= issue_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_prio_deco_pipe.sv
// Directed testbench for prio_deco_pipe.
module tb_prio_deco_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_code;
    logic       in_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_onehot;
    logic [7:0] done;
    logic [7:0] busy;
    logic [7:0] issue_cnt;

    int checks;
    int failures;

    prio_deco_pipe #(
        .CODE_W (3),
        .N_OUT  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .done       (done),
        .busy       (busy),
        .issue_cnt  (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_code   = '0;
        in_en     = 1'b0;
        out_ready = 1'b1;
        done      = '0;

        // Reset state
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_onehot", 32'(out_onehot), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cnt", 32'(issue_cnt), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'h1);

        // Streaming codes 0..7, done one cycle after each fire
        for (int i = 0; i <= 10; i++) begin
            in_valid = (i < 8);
            in_code  = 3'(i);
            in_en    = 1'b1;
            done     = (i >= 3) ? 8'(1 << (i - 3)) : 8'h00;
            #1;
            if (i < 8) chk("stream_in_ready", 32'(in_ready), 32'h1);
            if (i >= 2 && i <= 9) begin
                chk("stream_valid", 32'(out_valid), 32'h1);
                chk("stream_onehot", 32'(out_onehot), 32'(1 << (i - 2)));
            end else begin
                chk("stream_idle", 32'(out_valid), 32'h0);
            end
            next();
        end
        in_valid = 1'b0;
        done     = '0;
        #1;
        chk("stream_cnt", 32'(issue_cnt), 32'd8);
        chk("stream_busy", 32'(busy), 32'h0);

        // Busy hazard on code 3
        in_valid = 1'b1; in_code = 3'd3; in_en = 1'b1;
        #1;
        chk("hz_accept1", 32'(in_ready), 32'h1);
        next();
        in_valid = 1'b0;
        #1;
        chk("hz_lat", 32'(out_valid), 32'h0);
        next();
        in_valid = 1'b1; in_code = 3'd3;
        #1;
        chk("hz_first_out", 32'(out_onehot), 32'h08);
        chk("hz_accept2", 32'(in_ready), 32'h1);
        next();
        in_valid = 1'b0;
        #1;
        chk("hz_busy", 32'(busy), 32'h08);
        chk("hz_stall_rdy", 32'(in_ready), 32'h0);
        chk("hz_stall_out", 32'(out_valid), 32'h0);
        next();
        #1;
        chk("hz_stall_rdy2", 32'(in_ready), 32'h0);
        chk("hz_stall_out2", 32'(out_valid), 32'h0);
        done = 8'h08;
        #1;
        chk("hz_release_rdy", 32'(in_ready), 32'h1);
        next();
        done = '0;
        #1;
        chk("hz_second_valid", 32'(out_valid), 32'h1);
        chk("hz_second_out", 32'(out_onehot), 32'h08);
        chk("hz_busy_clr", 32'(busy), 32'h00);
        next();
        #1;
        chk("hz_busy_reset", 32'(busy), 32'h08);
        chk("hz_cnt", 32'(issue_cnt), 32'd10);
        chk("hz_drained", 32'(out_valid), 32'h0);

        // Null token on a busy line
        in_valid = 1'b1; in_code = 3'd5; in_en = 1'b1;
        next();
        in_valid = 1'b0;
        next();
        #1;
        chk("null_setup_out", 32'(out_onehot), 32'h20);
        next();
        #1;
        chk("null_setup_busy", 32'(busy), 32'h28);
        chk("null_setup_cnt", 32'(issue_cnt), 32'd11);
        in_valid = 1'b1; in_code = 3'd5; in_en = 1'b0;
        #1;
        chk("null_accept", 32'(in_ready), 32'h1);
        next();
        in_valid = 1'b0;
        #1;
        chk("null_lat", 32'(out_valid), 32'h0);
        next();
        #1;
        chk("null_valid", 32'(out_valid), 32'h1);
        chk("null_onehot", 32'(out_onehot), 32'h00);
        next();
        #1;
        chk("null_busy", 32'(busy), 32'h28);
        chk("null_cnt", 32'(issue_cnt), 32'd11);
        chk("null_drained", 32'(out_valid), 32'h0);
        done = 8'h28;
        next();
        done = '0;
        #1;
        chk("null_cleanup", 32'(busy), 32'h00);

        // Backpressure: out_ready low for 4 cycles, 3 tokens offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 3'd0; in_en = 1'b1;
        #1;
        chk("bp_acc0", 32'(in_ready), 32'h1);
        next();
        in_code = 3'd1;
        #1;
        chk("bp_acc1", 32'(in_ready), 32'h1);
        chk("bp_lat", 32'(out_valid), 32'h0);
        next();
        in_code = 3'd2;
        #1;
        chk("bp_full_rdy", 32'(in_ready), 32'h0);
        chk("bp_valid", 32'(out_valid), 32'h1);
        chk("bp_hold1", 32'(out_onehot), 32'h01);
        next();
        #1;
        chk("bp_full_rdy2", 32'(in_ready), 32'h0);
        chk("bp_hold2", 32'(out_onehot), 32'h01);
        next();
        out_ready = 1'b1;
        #1;
        chk("bp_out0", 32'(out_onehot), 32'h01);
        chk("bp_acc2", 32'(in_ready), 32'h1);
        next();
        in_valid = 1'b0;
        #1;
        chk("bp_out1_valid", 32'(out_valid), 32'h1);
        chk("bp_out1", 32'(out_onehot), 32'h02);
        next();
        done = 8'h04;
        #1;
        chk("bp_out2", 32'(out_onehot), 32'h04);
        next();
        done = '0;
        #1;
        chk("bp_set_wins", 32'(busy), 32'h07);
        chk("bp_cnt", 32'(issue_cnt), 32'd14);
        chk("bp_drained", 32'(out_valid), 32'h0);
        done = 8'h80;
        next();
        done = '0;
        #1;
        chk("done_not_busy", 32'(busy), 32'h07);
        done = 8'h07;
        next();
        done = '0;
        #1;
        chk("bp_cleanup", 32'(busy), 32'h00);

        // Wrap: reset, then 256 non-null issues
        rst_n = 1'b0;
        #1;
        chk("wrap_rst_cnt", 32'(issue_cnt), 32'd0);
        next();
        rst_n = 1'b1;
        for (int i = 0; i <= 258; i++) begin
            in_valid = (i < 256);
            in_code  = 3'(i % 8);
            in_en    = 1'b1;
            done     = (i >= 3) ? 8'(1 << ((i - 3) % 8)) : 8'h00;
            #1;
            if (i < 256) chk("wrap_rdy", 32'(in_ready), 32'h1);
            if (i >= 2 && i <= 257) chk("wrap_onehot", 32'(out_onehot), 32'(1 << ((i - 2) % 8)));
            next();
        end
        in_valid = 1'b0;
        done     = '0;
        #1;
        chk("wrap_cnt", 32'(issue_cnt), 32'd0);
        chk("wrap_busy", 32'(busy), 32'h00);

        // Reset while out_valid = 1
        in_valid = 1'b1; in_code = 3'd1; in_en = 1'b1;
        next();
        in_valid = 1'b0;
        next();
        next();
        #1;
        chk("mid_busy", 32'(busy), 32'h02);
        chk("mid_cnt", 32'(issue_cnt), 32'd1);
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 3'd4;
        next();
        in_code = 3'd6;
        next();
        in_valid = 1'b0;
        #1;
        chk("mid_valid", 32'(out_valid), 32'h1);
        chk("mid_onehot", 32'(out_onehot), 32'h10);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'h0);
        chk("arst_onehot", 32'(out_onehot), 32'h00);
        chk("arst_busy", 32'(busy), 32'h00);
        chk("arst_cnt", 32'(issue_cnt), 32'd0);
        chk("arst_rdy", 32'(in_ready), 32'h0);
        next();
        next();
        rst_n = 1'b1;
        #1;
        chk("arel_rdy", 32'(in_ready), 32'h1);
        chk("arel_valid", 32'(out_valid), 32'h0);
        out_ready = 1'b1;
        next();
        next();
        #1;
        chk("discard_valid", 32'(out_valid), 32'h0);
        chk("discard_cnt", 32'(issue_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
